// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Constants and helpers shared by the front end of the 5-stage RISC-V core.
//   XLEN             : architectural register / address width
//   PC_STEP          : byte increment between sequential instructions
//   NOP_INST         : bubble instruction, addi x0,x0,0
//   RESET_PC_DEFAULT : default reset vector
//   align_pc()       : clears the low two address bits; there is no
//                      compressed ISA, so every PC is word aligned
// ---------------------------------------------------------------------------
package core_pkg;

    localparam int                XLEN             = 32;
    localparam logic [XLEN-1:0]   PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0]   NOP_INST         = 32'h0000_0013;
    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;

    // Masking keeps every input bit in use.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program counter register for the fetch stage.
// Priority each rising edge: reset > flush (redirect) > stall (hold) > +4.
// Ports:
//   clk_i            in   core clock
//   rst_i            in   synchronous active-high reset
//   stall_i          in   hold the PC
//   flush_i          in   redirect to branch_target_i (word aligned)
//   branch_target_i  in   redirect address
//   pc_o             out  current PC (pc_q)
// ---------------------------------------------------------------------------
module pc_gen
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (flush_i) begin
            pc_d = align_pc(branch_target_i);
        end else if (!stall_i) begin
            // Natural 32-bit overflow wraps 0xFFFF_FFFC to 0.
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
// Fetch stage plus IF/ID pipeline register. Drives the instruction-memory
// address from the PC and captures the fetched word and its PC for ID.
// A stall holds everything; a flush redirects the PC and inserts a bubble.
// Optional feature: define IF_ID_PERF_CNT_EN to add stall/flush counters.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   imem_addr_o   out   instruction address (= PC, combinational)
//   imem_data_i   in    instruction word for imem_addr_o, same cycle
//   stall_i       in    load-use stall from the hazard unit
//   flush_i       in    taken branch, resolved in ID
//   branch_target_i in  redirect address used with flush_i
//   pc_o, inst_o  out   PC and instruction held in IF/ID
//   valid_o       out   1 = real instruction, 0 = bubble
//   stall_cnt_o   out   (IF_ID_PERF_CNT_EN) count of effective stall edges
//   flush_cnt_o   out   (IF_ID_PERF_CNT_EN) count of flush edges
// ---------------------------------------------------------------------------
module if_id_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = core_pkg::NOP_INST
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
`endif
);

    logic [XLEN-1:0] fetch_pc;

    pc_gen #(
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .pc_o            (fetch_pc)
    );

    assign imem_addr_o = fetch_pc;

    // IF/ID register
    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] inst_q,  inst_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            // Word fetched this cycle is on the wrong path: drop it.
            pc_d    = '0;
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            pc_d    = fetch_pc;
            inst_d  = imem_data_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        // A stall coinciding with a flush is overridden, so it is not counted.
        if (stall_i && !flush_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// ---------------------------------------------------------------------------
// tb_if_id_stage
// Drives if_id_stage (RESET_PC = 0x100) with directed and random
// reset/stall/flush sequences against a combinational instruction memory.
// Expected IF/ID contents are queued when stimulus is applied and compared
// after the following rising edge.
// ---------------------------------------------------------------------------
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] target = '0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        valid_out;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    if_id_stage #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .imem_addr_o     (imem_addr),
        .imem_data_i     (imem_data),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (target),
        .pc_o            (pc_out),
        .inst_o          (inst_out),
        .valid_o         (valid_out)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_000A;
            32'h0000_0104: return 32'h0000_000B;
            32'h0000_0108: return 32'h0000_000C;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] addr;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    exp_t sb[$];

    // reference state
    logic [31:0] m_pc   = 32'h0000_0100;
    logic [31:0] m_pco  = '0;
    logic [31:0] m_inst = 32'h0000_0013;
    logic        m_valid = 1'b0;
    logic [31:0] m_scnt = '0;
    logic [31:0] m_fcnt = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic [31:0] tgt);
        exp_t e;
        @(negedge clk);
        rst = r; stall = s; flush = f; target = tgt;
        if (r) begin
            m_pc = 32'h0000_0100; m_pco = '0; m_inst = 32'h13; m_valid = 1'b0;
            m_scnt = '0; m_fcnt = '0;
        end else if (f) begin
            m_pc = {tgt[31:2], 2'b00}; m_pco = '0; m_inst = 32'h13; m_valid = 1'b0;
            m_fcnt = m_fcnt + 1;
        end else if (s) begin
            m_scnt = m_scnt + 1;
        end else begin
            m_pco = m_pc; m_inst = mem_word(m_pc); m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pco; e.inst = m_inst; e.valid = m_valid; e.addr = m_pc;
        e.scnt = m_scnt; e.fcnt = m_fcnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        $display("step rst=%0b stall=%0b flush=%0b tgt=%h -> addr=%h pc=%h inst=%h valid=%0b",
                 r, s, f, tgt, imem_addr, pc_out, inst_out, valid_out);
        check("pc_o", pc_out, e.pc);
        check("inst_o", inst_out, e.inst);
        check("valid_o", {31'd0, valid_out}, {31'd0, e.valid});
        check("imem_addr_o", imem_addr, e.addr);
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt_o", stall_cnt, e.scnt);
        check("flush_cnt_o", flush_cnt, e.fcnt);
`endif
    endtask

    initial begin
        // reset
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("rst_inst_nop", inst_out, 32'h0000_0013);
        check("rst_addr", imem_addr, 32'h0000_0100);

        // free run, then 2-cycle stall at 0x108
        step(0, 0, 0, 0);
        check("plan_inst_A", inst_out, 32'h0000_000A);
        check("plan_addr_104", imem_addr, 32'h0000_0104);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("plan_stall_inst_B", inst_out, 32'h0000_000B);
        check("plan_stall_addr", imem_addr, 32'h0000_0108);
        step(0, 0, 0, 0);
        check("plan_inst_C", inst_out, 32'h0000_000C);
        check("plan_pc_108", pc_out, 32'h0000_0108);

        // flush to misaligned target
        step(0, 0, 1, 32'h0000_0203);
        check("plan_flush_addr", imem_addr, 32'h0000_0200);
        step(0, 0, 0, 0);
        check("plan_flush_pc", pc_out, 32'h0000_0200);

        // flush + stall together
        step(0, 1, 1, 32'h0000_0400);
        check("plan_flstall_addr", imem_addr, 32'h0000_0400);
        step(0, 0, 0, 0);

        // flush then stall: bubble held
        step(0, 0, 1, 32'h0000_0800);
        step(0, 1, 0, 0);
        check("flush_stall_valid", {31'd0, valid_out}, 32'd0);

        // PC wrap
        step(0, 0, 1, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        step(0, 0, 0, 0);

        // reset during stall
        step(0, 1, 0, 0);
        step(1, 1, 1, 32'h0000_0A00);
        check("rst_mid_stall_valid", {31'd0, valid_out}, 32'd0);

        // counters: 2 stalls, 1 flush, then reset
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'h0000_0300);
`ifdef IF_ID_PERF_CNT_EN
        check("plan_stall_cnt", stall_cnt, 32'd2);
        check("plan_flush_cnt", flush_cnt, 32'd1);
`endif
        step(1, 0, 0, 0);
`ifdef IF_ID_PERF_CNT_EN
        check("plan_cnt_clear", stall_cnt | flush_cnt, 32'd0);
`endif

        // random mix
        for (int i = 0; i < 60; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 5) == 0, $urandom());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
